wb_regfile: RTL and testbench

//  Writeback-stage consumer of the MEM/WB pipeline register outputs. Selects the

---
 rtl/wb_regfile_if.sv | 29 ++
 rtl/wb_regfile.sv | 58 +++++
 tb/tb_wb_regfile.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback fields in, decode read ports and commit status out.
// Combinational reads, one-cycle commit; no backpressure (always accepts).
interface wb_regfile_if #(
    parameter int XLEN = 32,
    parameter int CNTW = 32
);
    logic            RegWriteW;
    logic [1:0]      ResultSrcW;
    logic [XLEN-1:0] ReadDataW;
    logic [XLEN-1:0] ALUResultW;
    logic [XLEN-1:0] PCPlus4W;
    logic [4:0]      RdW;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic [XLEN-1:0] ResultW;
    logic [CNTW-1:0] WbCount;

    modport master (
        output RegWriteW, ResultSrcW, ReadDataW, ALUResultW, PCPlus4W, RdW, Rs1D, Rs2D,
        input  RD1D, RD2D, ResultW, WbCount
    );

    modport slave (
        input  RegWriteW, ResultSrcW, ReadDataW, ALUResultW, PCPlus4W, RdW, Rs1D, Rs2D,
        output RD1D, RD2D, ResultW, WbCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback result select, integer register file with write-through read bypass, commit counter.
// Reads/result combinational, commit on next rising edge; no backpressure.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNTW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    wb_regfile_if.slave    bus
);
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] result;
    logic [CNTW-1:0] wb_count;
    logic            wr_hit_ok;
    logic            commit;

    always_comb begin
        case (bus.ResultSrcW)
            2'b01:   result = bus.ReadDataW;
            2'b10:   result = bus.PCPlus4W;
            default: result = bus.ALUResultW;
        endcase
    end

    assign wr_hit_ok = bus.RegWriteW && (bus.RdW != 5'd0);
    assign commit    = wr_hit_ok && ({1'b0, bus.RdW} < NREGS_L);

    // regs[0] is cleared by reset and never written, so it stays a hard zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wb_count <= '0;
        end else if (commit) begin
            regs[bus.RdW] <= result;
            wb_count      <= wb_count + 1'b1;
        end
    end

    // Bypass is deliberately not gated by rst; only the array is cleared.
    always_comb begin
        bus.RD1D = '0;
        bus.RD2D = '0;
        if (bus.Rs1D != 5'd0 && {1'b0, bus.Rs1D} < NREGS_L) begin
            bus.RD1D = (wr_hit_ok && bus.RdW == bus.Rs1D) ? result : regs[bus.Rs1D];
        end
        if (bus.Rs2D != 5'd0 && {1'b0, bus.Rs2D} < NREGS_L) begin
            bus.RD2D = (wr_hit_ok && bus.RdW == bus.Rs2D) ? result : regs[bus.Rs2D];
        end
    end

    assign bus.ResultW = result;
    assign bus.WbCount = wb_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile built with a 4-bit commit counter so wrap is reachable.
module tb_wb_regfile;
    localparam int XLEN = 32;
    localparam int CNTW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_regfile_if #(.XLEN(XLEN), .CNTW(CNTW)) bus ();

    wb_regfile #(.XLEN(XLEN), .NREGS(32), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] v);
        bus.RegWriteW  = 1'b1;
        bus.RdW        = rd;
        bus.ResultSrcW = src;
        bus.ReadDataW  = (src == 2'b01) ? v : 32'h0BAD_0001;
        bus.PCPlus4W   = (src == 2'b10) ? v : 32'h0BAD_0002;
        bus.ALUResultW = (src == 2'b00 || src == 2'b11) ? v : 32'h0BAD_0003;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.RegWriteW  = 1'b0;
        bus.ResultSrcW = 2'b00;
        bus.ReadDataW  = '0;
        bus.ALUResultW = '0;
        bus.PCPlus4W   = '0;
        bus.RdW        = '0;
        bus.Rs1D       = '0;
        bus.Rs2D       = '0;

        // 1: reset clears everything
        tick();
        rst = 1'b0;
        #1;
        chk("reset_wbcount", 32'(bus.WbCount), 32'd0);
        for (int i = 0; i < 32; i++) begin
            bus.Rs1D = 5'(i);
            bus.Rs2D = 5'(31 - i);
            #1;
            chk($sformatf("reset_rd1_x%0d", i), bus.RD1D, 32'd0);
            chk($sformatf("reset_rd2_x%0d", 31 - i), bus.RD2D, 32'd0);
        end

        // 2: same-cycle bypass, then stored value
        wr(5'd5, 2'b00, 32'hDEAD_BEEF);
        bus.Rs1D = 5'd5;
        bus.Rs2D = 5'd6;
        #1;
        chk("bypass_rd1_x5", bus.RD1D, 32'hDEAD_BEEF);
        chk("bypass_rd2_x6", bus.RD2D, 32'd0);
        chk("bypass_wbcount_pre", 32'(bus.WbCount), 32'd0);
        tick();
        bus.RegWriteW = 1'b0;
        #1;
        chk("stored_rd1_x5", bus.RD1D, 32'hDEAD_BEEF);
        chk("stored_wbcount", 32'(bus.WbCount), 32'd1);

        // 3: x0 never written or bypassed
        wr(5'd0, 2'b00, 32'h0000_1234);
        bus.Rs1D = 5'd0;
        bus.Rs2D = 5'd0;
        #1;
        chk("x0_bypass_rd1", bus.RD1D, 32'd0);
        chk("x0_bypass_rd2", bus.RD2D, 32'd0);
        tick();
        bus.RegWriteW = 1'b0;
        #1;
        chk("x0_after_rd1", bus.RD1D, 32'd0);
        chk("x0_after_rd2", bus.RD2D, 32'd0);
        chk("x0_wbcount", 32'(bus.WbCount), 32'd1);

        // 4: each result source
        wr(5'd1, 2'b01, 32'hA5A5_A5A5);
        #1;
        chk("result_src01", bus.ResultW, 32'hA5A5_A5A5);
        tick();
        wr(5'd2, 2'b10, 32'h0000_0104);
        #1;
        chk("result_src10", bus.ResultW, 32'h0000_0104);
        tick();
        wr(5'd3, 2'b11, 32'h0000_0007);
        #1;
        chk("result_src11", bus.ResultW, 32'h0000_0007);
        tick();
        bus.RegWriteW = 1'b0;
        bus.Rs1D = 5'd1;
        bus.Rs2D = 5'd2;
        #1;
        chk("readback_x1", bus.RD1D, 32'hA5A5_A5A5);
        chk("readback_x2", bus.RD2D, 32'h0000_0104);
        bus.Rs1D = 5'd3;
        #1;
        chk("readback_x3", bus.RD1D, 32'h0000_0007);
        chk("src_wbcount", 32'(bus.WbCount), 32'd4);

        // no bypass without RegWriteW even when indices match
        bus.RdW = 5'd3;
        bus.ALUResultW = 32'h0000_0BAD;
        bus.ResultSrcW = 2'b00;
        #1;
        chk("nowrite_nobypass_x3", bus.RD1D, 32'h0000_0007);

        // both ports bypass the same index
        wr(5'd7, 2'b00, 32'h0000_0077);
        bus.Rs1D = 5'd7;
        bus.Rs2D = 5'd7;
        #1;
        chk("dual_bypass_rd1", bus.RD1D, 32'h0000_0077);
        chk("dual_bypass_rd2", bus.RD2D, 32'h0000_0077);
        tick();

        // 5: reset drops a concurrent write; bypass still visible during rst
        wr(5'd9, 2'b00, 32'h0000_0055);
        tick();
        bus.RegWriteW = 1'b0;
        bus.Rs1D = 5'd9;
        bus.Rs2D = 5'd1;
        #1;
        chk("pre_rst_x9", bus.RD1D, 32'h0000_0055);
        chk("pre_rst_wbcount", 32'(bus.WbCount), 32'd6);
        rst = 1'b1;
        wr(5'd9, 2'b00, 32'h0000_0066);
        #1;
        chk("rst_bypass_x9", bus.RD1D, 32'h0000_0066);
        tick();
        rst = 1'b0;
        bus.RegWriteW = 1'b0;
        #1;
        chk("post_rst_x9", bus.RD1D, 32'd0);
        chk("post_rst_x1", bus.RD2D, 32'd0);
        chk("post_rst_wbcount", 32'(bus.WbCount), 32'd0);

        // 6: 15 commits fill the 4-bit counter, one more wraps it
        for (int i = 0; i < 15; i++) begin
            wr(5'd10, 2'b00, 32'(i + 1));
            tick();
        end
        bus.RegWriteW = 1'b0;
        bus.Rs1D = 5'd10;
        #1;
        chk("full_wbcount", 32'(bus.WbCount), 32'd15);
        chk("full_x10", bus.RD1D, 32'd15);
        wr(5'd11, 2'b00, 32'h0000_00AB);
        tick();
        bus.RegWriteW = 1'b0;
        bus.Rs2D = 5'd11;
        #1;
        chk("wrap_wbcount", 32'(bus.WbCount), 32'd0);
        chk("wrap_x11", bus.RD2D, 32'h0000_00AB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
